// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC coefficient reconstruction path.
//   MAX_COEFF     coefficients per block
//   LEVEL_W       signed level width (matches LPU LevelOut)
//   MAX_COEFF_AW  scan-position address width
//   level_t       signed level type
//   crec_state_e  reconstruction FSM states
package cavlc_pkg;
  localparam int MAX_COEFF    = 16;
  localparam int LEVEL_W      = 13;
  localparam int MAX_COEFF_AW = 4;

  typedef logic signed [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {IDLE, COLLECT, PLACE, EMIT} crec_state_e;
endpackage

// File: rtl/level_buf.sv
// Level buffer: MAX_COEFF x LEVEL_W register file, one write and one
// combinational read port. Holds one block's levels, high frequency first.
//   Clk, nReset  clock / async active-low reset (contents cleared)
//   we/waddr/wdata  write port
//   raddr/rdata     read port
module level_buf import cavlc_pkg::*; (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic                    we,
  input  logic [MAX_COEFF_AW-1:0] waddr,
  input  level_t                  wdata,
  input  logic [MAX_COEFF_AW-1:0] raddr,
  output level_t                  rdata
);
  logic [MAX_COEFF-1:0][LEVEL_W-1:0] mem;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)  mem <= '0;
    else if (we)  mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/coeff_reconstruct.sv
// Coefficient reconstruction: buffers a block's levels, places each at its
// scan position using run_before values, then streams all MAX_COEFF
// coefficients (zeros included) in scan order over valid/ready.
//   Start/TotalCoeff/TotalZeros  block start and header
//   LevelIn/LevelWr              levels from the LPU
//   RunIn/RunValid/RunReady      run_before handshake
//   OutValid/OutReady/OutAddr/OutCoeff/OutLast  output stream
//   BlockDone  pulse after last beat; Busy  not idle; RunErr  sticky error
module coeff_reconstruct import cavlc_pkg::*; (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic [4:0]         TotalCoeff,
  input  logic [3:0]         TotalZeros,
  input  logic [LEVEL_W-1:0] LevelIn,
  input  logic               LevelWr,
  input  logic [3:0]         RunIn,
  input  logic               RunValid,
  output logic               RunReady,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [3:0]         OutAddr,
  output logic [LEVEL_W-1:0] OutCoeff,
  output logic               OutLast,
  output logic               BlockDone,
  output logic               Busy,
  output logic               RunErr
);
  crec_state_e state, state_nxt;

  logic [4:0] tc, lvlcnt, idx, zleft;
  // Six bits so TC+TZ-1 cannot alias into range for malformed headers.
  logic [5:0] pos;
  logic [3:0] emitcnt;
  logic [MAX_COEFF-1:0][LEVEL_W-1:0] coeff;
  logic       blockdone_q, runerr_q;
  level_t     lvl_rd;

  logic       lvl_wr, collect_done, need_run, place_step, place_last, place_ok;
  logic       run_ovf, emit_acc, emit_last, start_err;
  logic [4:0] run_raw, run;
  logic [5:0] hdr_sum;

  assign lvl_wr       = (state == COLLECT) && LevelWr && (lvlcnt < tc) && !Start;
  assign collect_done = (lvlcnt == tc) || (lvl_wr && (lvlcnt + 5'd1 == tc));
  assign need_run     = (idx < tc - 5'd1) && (zleft != 5'd0);
  assign place_step   = (state == PLACE) && (!need_run || RunValid);
  assign place_last   = (idx == tc - 5'd1);
  assign place_ok     = (pos < 6'(MAX_COEFF)) && (idx < 5'(MAX_COEFF));
  assign run_raw      = need_run ? {1'b0, RunIn} : 5'd0;
  assign run_ovf      = run_raw > zleft;
  assign run          = run_ovf ? zleft : run_raw;
  assign emit_acc     = (state == EMIT) && OutReady;
  assign emit_last    = (emitcnt == 4'(MAX_COEFF-1));
  assign hdr_sum      = {1'b0, TotalCoeff} + {2'b0, TotalZeros};
  assign start_err    = (TotalCoeff > 5'(MAX_COEFF)) || (hdr_sum > 6'(MAX_COEFF));

  level_buf u_lvl (
    .Clk   (Clk),
    .nReset(nReset),
    .we    (lvl_wr && (lvlcnt < 5'(MAX_COEFF))),
    .waddr (lvlcnt[3:0]),
    .wdata (level_t'(LevelIn)),
    .raddr (idx[3:0]),
    .rdata (lvl_rd)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Start) state_nxt = (TotalCoeff == 5'd0) ? EMIT : COLLECT;
    else begin
      case (state)
        COLLECT: if (collect_done)              state_nxt = PLACE;
        PLACE:   if (place_step && place_last)  state_nxt = EMIT;
        EMIT:    if (emit_acc && emit_last)     state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    RunReady  = (state == PLACE) && need_run;
    OutValid  = (state == EMIT);
    OutAddr   = OutValid ? emitcnt : 4'd0;
    OutCoeff  = OutValid ? coeff[emitcnt] : '0;
    OutLast   = OutValid && emit_last;
    Busy      = (state != IDLE);
    BlockDone = blockdone_q;
    RunErr    = runerr_q;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tc          <= '0;
      lvlcnt      <= '0;
      idx         <= '0;
      zleft       <= '0;
      pos         <= '0;
      emitcnt     <= '0;
      coeff       <= '0;
      blockdone_q <= 1'b0;
      runerr_q    <= 1'b0;
    end else begin
      blockdone_q <= 1'b0;
      if (Start) begin
        tc       <= TotalCoeff;
        lvlcnt   <= '0;
        idx      <= '0;
        zleft    <= {1'b0, TotalZeros};
        pos      <= hdr_sum - 6'd1;
        emitcnt  <= '0;
        coeff    <= '0;
        runerr_q <= start_err;
      end else begin
        if (lvl_wr) lvlcnt <= lvlcnt + 5'd1;
        if (place_step) begin
          if (place_ok) coeff[pos[3:0]] <= lvl_rd;
          if (run_ovf)  runerr_q <= 1'b1;
          zleft <= zleft - run;
          pos   <= pos - 6'd1 - {1'b0, run};
          idx   <= idx + 5'd1;
        end
        if (emit_acc) begin
          emitcnt <= emitcnt + 4'd1;
          if (emit_last) blockdone_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_coeff_reconstruct.sv
module tb_coeff_reconstruct;
  logic        Clk = 1'b0, nReset = 1'b0, Start = 1'b0;
  logic [4:0]  TotalCoeff = '0;
  logic [3:0]  TotalZeros = '0;
  logic [12:0] LevelIn = '0;
  logic        LevelWr = 1'b0;
  logic [3:0]  RunIn = '0;
  logic        RunValid = 1'b0;
  logic        RunReady, OutValid;
  logic        OutReady = 1'b0;
  logic [3:0]  OutAddr;
  logic [12:0] OutCoeff;
  logic        OutLast, BlockDone, Busy, RunErr;

  coeff_reconstruct dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .TotalCoeff(TotalCoeff),
    .TotalZeros(TotalZeros), .LevelIn(LevelIn), .LevelWr(LevelWr),
    .RunIn(RunIn), .RunValid(RunValid), .RunReady(RunReady),
    .OutValid(OutValid), .OutReady(OutReady), .OutAddr(OutAddr),
    .OutCoeff(OutCoeff), .OutLast(OutLast), .BlockDone(BlockDone),
    .Busy(Busy), .RunErr(RunErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int tc_m, tz_m, nruns;
  int lv[32];
  int rn[32];
  int exp_c[16];
  int exp_err, exp_runs;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk coefficients from highest frequency down, each one
  // sitting below the previous by 1 + its run of zeros.
  function automatic void model();
    int p, zl, r;
    for (int k = 0; k < 16; k++) exp_c[k] = 0;
    exp_err  = (tc_m > 16 || tc_m + tz_m > 16) ? 1 : 0;
    exp_runs = 0;
    p  = tc_m + tz_m - 1;
    zl = tz_m;
    for (int i = 0; i < tc_m; i++) begin
      r = 0;
      if (i < tc_m - 1 && zl > 0) begin r = rn[exp_runs]; exp_runs++; end
      if (r > zl) begin exp_err = 1; r = zl; end
      if (p >= 0 && p < 16 && i < 16) exp_c[p] = lv[i];
      p  -= 1 + r;
      zl -= r;
    end
  endfunction

  task automatic rand_block(input int tc, input int tz);
    int zl;
    tc_m = tc; tz_m = tz; nruns = 0; zl = tz;
    for (int i = 0; i < 32; i++) lv[i] = int'($urandom_range(0, 8190)) - 4095;
    for (int i = 0; i < tc - 1; i++)
      if (zl > 0) begin
        rn[nruns] = int'($urandom_range(0, zl));
        zl -= rn[nruns];
        nruns++;
      end
  endtask

  task automatic start_block();
    @(posedge Clk); #1;
    Start = 1'b1; TotalCoeff = 5'(tc_m); TotalZeros = 4'(tz_m);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic write_levels(input bit gaps);
    for (int i = 0; i < tc_m; i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin @(posedge Clk); #1; end
      LevelWr = 1'b1; LevelIn = 13'(lv[i]);
      @(posedge Clk); #1;
      LevelWr = 1'b0;
    end
  endtask

  task automatic serve(input string tag, input bit rnd_rdy, input bit lat_chk);
    int ri = 0, nb = 0, bd = 0, rr = 0, cyc = 0, post = 0, first = -1;
    int s_addr = 0, s_coeff = 0;
    bit stalled = 0, run_acc;
    model();
    while (cyc < 800 && !(nb >= 16 && post >= 3)) begin
      RunValid = (ri < nruns);
      RunIn    = 4'(rn[ri]);
      OutReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge Clk);
      run_acc = RunReady && RunValid;
      if (RunReady)  rr++;
      if (BlockDone) bd++;
      if (OutValid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk({tag, " hold addr"}, int'(OutAddr), s_addr);
          chk({tag, " hold coeff"}, int'($signed(OutCoeff)), s_coeff);
        end
        if (OutReady) begin
          chk({tag, " addr"}, int'(OutAddr), nb);
          chk({tag, " coeff"}, int'($signed(OutCoeff)), exp_c[nb]);
          chk({tag, " last"}, int'(OutLast), (nb == 15) ? 1 : 0);
          nb++;
          stalled = 0;
        end else begin
          stalled = 1;
          s_addr  = int'(OutAddr);
          s_coeff = int'($signed(OutCoeff));
        end
      end
      if (nb >= 16) post++;
      cyc++;
      @(posedge Clk); #1;
      if (run_acc) ri++;
    end
    RunValid = 1'b0; OutReady = 1'b0;
    chk({tag, " beats"}, nb, 16);
    chk({tag, " blockdone"}, bd, 1);
    chk({tag, " runready cycles"}, rr, exp_runs);
    chk({tag, " runerr"}, int'(RunErr), exp_err);
    chk({tag, " busy end"}, int'(Busy), 0);
    if (lat_chk) chk({tag, " latency"}, first, tc_m);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst outvalid", int'(OutValid), 0);
    chk("rst runready", int'(RunReady), 0);
    chk("rst busy", int'(Busy), 0);
    chk("rst blockdone", int'(BlockDone), 0);
    chk("rst runerr", int'(RunErr), 0);
    chk("rst outaddr", int'(OutAddr), 0);
    chk("rst outcoeff", int'(OutCoeff), 0);
    chk("rst outlast", int'(OutLast), 0);
    @(negedge Clk); nReset = 1'b1;

    // TC=3 TZ=2, levels 1,-1,5, runs 1,1
    tc_m = 3; tz_m = 2; lv[0] = 1; lv[1] = -1; lv[2] = 5;
    rn[0] = 1; rn[1] = 1; nruns = 2;
    start_block(); write_levels(0); serve("tc3tz2", 0, 1);
    chk("tc3tz2 c4", exp_c[4], 1);

    // TC=4 TZ=0: no runs, positions 3..0
    tc_m = 4; tz_m = 0; lv[0] = 7; lv[1] = -3; lv[2] = 2; lv[3] = -9; nruns = 0;
    start_block(); write_levels(0); serve("tc4tz0", 0, 1);

    // TC=0: zero stream right after Start
    tc_m = 0; tz_m = 0; nruns = 0;
    start_block(); serve("tc0", 0, 1);

    // TC=2 TZ=3 run=5: clamp to 3
    tc_m = 2; tz_m = 3; lv[0] = 100; lv[1] = -200; rn[0] = 5; nruns = 1;
    start_block(); write_levels(0); serve("runclamp", 0, 1);

    // header exceeding block size
    rand_block(16, 3);
    start_block(); write_levels(1); serve("hdrerr", 1, 0);

    // randomized blocks with random level gaps and output backpressure
    for (int b = 0; b < 6; b++) begin
      int t;
      t = int'($urandom_range(1, 16));
      rand_block(t, int'($urandom_range(0, 16 - t)));
      start_block(); write_levels(1); serve($sformatf("rnd%0d", b), 1, 0);
    end

    // abort mid-PLACE: block A stalls on a run, then block B replaces it
    rand_block(8, 6);
    start_block(); write_levels(0);
    @(negedge Clk);
    chk("abort runready", int'(RunReady), 1);
    @(posedge Clk); #1;
    rand_block(10, 4);
    start_block(); write_levels(1); serve("abort newblk", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
